// File: rtl/qam_rx_pkg.sv
// Shared types and defaults for the QAM16 receive-side decimator.
package qam_rx_pkg;

  localparam int QAM_DW  = 4;
  localparam int QAM_OSR = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/qam_phase_counter.sv
// Symbol phase counter: sync realignment, advance/retard slips and phase-match flag.
// With QAM_DOWNSAMPLER_INTEGRATE_EN the match fires on the last phase of the symbol.
module qam_phase_counter
  import qam_rx_pkg::*;
#(
  parameter int OSR = QAM_OSR,
  parameter int PW  = $clog2(OSR)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          in_valid_i,
  input  logic          sync_i,
  input  logic          advance_i,
  input  logic          retard_i,
  input  logic          track_i,
  input  logic [PW-1:0] phase_sel_i,
`ifdef QAM_DOWNSAMPLER_INTEGRATE_EN
  output logic          active_o,
`endif
  output logic          match_o
);

  logic [PW-1:0] cnt_q, cnt_d, p_s, tgt_s;
  logic          active_s;

  // Effective phase, slip handling and match against the target phase
  always_comb begin
    active_s = in_valid_i & en_i & (track_i | sync_i);
    p_s      = sync_i ? {PW{1'b0}} : cnt_q;
    cnt_d    = cnt_q;
    if (!en_i) begin
      cnt_d = {PW{1'b0}};
    end else if (active_s) begin
      if (!track_i) begin
        cnt_d = PW'(1);
      end else if (advance_i & !retard_i) begin
        cnt_d = p_s + PW'(2);
      end else if (retard_i & !advance_i) begin
        cnt_d = p_s;
      end else begin
        cnt_d = p_s + PW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
`ifdef QAM_DOWNSAMPLER_INTEGRATE_EN
    tgt_s = PW'(OSR - 1);
`else
    tgt_s = phase_sel_i;
`endif
    match_o = active_s & (p_s == tgt_s);
  end

`ifdef QAM_DOWNSAMPLER_INTEGRATE_EN
  assign active_o = active_s;
`endif

  // Phase counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/qam_downsampler.sv
// QAM16 receive symbol decimator: one I/Q symbol per OSR valid samples, sync aligned.
// Build option QAM_DOWNSAMPLER_INTEGRATE_EN swaps single-phase pick for integrate-and-dump.
module qam_downsampler
  import qam_rx_pkg::*;
#(
  parameter int OSR = QAM_OSR,
  parameter int PW  = $clog2(OSR),
  parameter int DW  = QAM_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 sync,
  input  logic signed [DW-1:0] iin,
  input  logic signed [DW-1:0] qin,
  input  logic        [PW-1:0] phase_sel,
  input  logic                 advance,
  input  logic                 retard,
  output logic signed [DW-1:0] isym,
  output logic signed [DW-1:0] qsym,
  output logic                 sym_valid,
  output logic                 locked
);

  state_e               state_q, state_d;
  logic                 locked_q, locked_d;
  logic                 sym_valid_q, sym_valid_d;
  logic signed [DW-1:0] isym_q, isym_d, qsym_q, qsym_d;
  logic                 match_s;

  qam_phase_counter #(.OSR(OSR), .PW(PW)) u_phase (
    .clk_i       (clk),
    .rst_ni      (reset),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .sync_i      (sync),
    .advance_i   (advance),
    .retard_i    (retard),
    .track_i     (state_q == S_TRACK),
    .phase_sel_i (phase_sel),
`ifdef QAM_DOWNSAMPLER_INTEGRATE_EN
    .active_o    (active_s),
`endif
    .match_o     (match_s)
  );

  // Acquire/track state machine; locked mirrors the next state
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && sync) begin
            state_d = S_TRACK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TRACK: state_d = S_TRACK;
        default: state_d = S_IDLE;
      endcase
    end
    locked_d = (state_d == S_TRACK);
  end

`ifdef QAM_DOWNSAMPLER_INTEGRATE_EN
  localparam int AW = DW + PW;
  logic                 active_s;
  logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [AW-1:0] sum_i_s, sum_q_s, avg_i_s, avg_q_s;

  // Integrate-and-dump; a sync sample restarts the running sum
  always_comb begin
    sum_i_s     = (sync ? {AW{1'b0}} : acc_i_q) + {{PW{iin[DW-1]}}, iin};
    sum_q_s     = (sync ? {AW{1'b0}} : acc_q_q) + {{PW{qin[DW-1]}}, qin};
    avg_i_s     = sum_i_s >>> PW;
    avg_q_s     = sum_q_s >>> PW;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    sym_valid_d = 1'b0;
    isym_d      = isym_q;
    qsym_d      = qsym_q;
    if (!en) begin
      acc_i_d = {AW{1'b0}};
      acc_q_d = {AW{1'b0}};
    end else if (active_s && match_s) begin
      acc_i_d     = {AW{1'b0}};
      acc_q_d     = {AW{1'b0}};
      sym_valid_d = 1'b1;
      isym_d      = avg_i_s[DW-1:0];
      qsym_d      = avg_q_s[DW-1:0];
    end else if (active_s) begin
      acc_i_d = sum_i_s;
      acc_q_d = sum_q_s;
    end else begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_i_q <= {AW{1'b0}};
      acc_q_q <= {AW{1'b0}};
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end
`else
  // Single-phase pick at the selected sample phase
  always_comb begin
    sym_valid_d = 1'b0;
    isym_d      = isym_q;
    qsym_d      = qsym_q;
    if (match_s) begin
      sym_valid_d = 1'b1;
      isym_d      = iin;
      qsym_d      = qin;
    end else begin
      sym_valid_d = 1'b0;
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      locked_q    <= 1'b0;
      sym_valid_q <= 1'b0;
      isym_q      <= {DW{1'b0}};
      qsym_q      <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      sym_valid_q <= sym_valid_d;
      isym_q      <= isym_d;
      qsym_q      <= qsym_d;
    end
  end

  assign isym      = isym_q;
  assign qsym      = qsym_q;
  assign sym_valid = sym_valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_qam_downsampler.sv
// Directed, table-driven bench for qam_downsampler (default single-phase pick build).
module tb_qam_downsampler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic              sync = 1'b0;
  logic signed [3:0] iin = 4'sd0;
  logic signed [3:0] qin = 4'sd0;
  logic        [3:0] phase_sel = 4'd0;
  logic              advance = 1'b0;
  logic              retard = 1'b0;
  logic signed [3:0] isym, qsym;
  logic              sym_valid, locked;

  int n_checks = 0;
  int n_fail   = 0;

  qam_downsampler dut (
    .clk       (clk),
    .reset     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .sync      (sync),
    .iin       (iin),
    .qin       (qin),
    .phase_sel (phase_sel),
    .advance   (advance),
    .retard    (retard),
    .isym      (isym),
    .qsym      (qsym),
    .sym_valid (sym_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ps;
    bit gap;
    int adv_n;
    int ret_n;
    int both_n;
    int c0, c1, c2;
    int i0, i1, i2;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; sync = 1'b0; advance = 1'b0; retard = 1'b0;
    iin = 4'sd0; qin = 4'sd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_plain(input int nsamp, input logic signed [3:0] v, output int strobes);
    strobes = 0;
    for (int j = 0; j < nsamp; j++) begin
      in_valid = 1'b1; sync = 1'b0; advance = 1'b0; retard = 1'b0;
      iin = v; qin = v;
      step();
      if (sym_valid) strobes++;
    end
    idle_inputs();
  endtask

  function automatic int pick(input int k, input int a, input int b, input int c);
    return (k == 0) ? a : ((k == 1) ? b : c);
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int k;
    int d;
    logic signed [3:0] dv;
    bit vld;
    do_reset();
    en = 1'b1;
    phase_sel = v.ps[3:0];
    n = 0;
    k = 0;
    for (int c = 0; c <= v.c2; c++) begin
      vld = !v.gap || (c % 2 == 0);
      if (vld) begin
        d  = (n % 16) - 8;
        dv = d[3:0];
        in_valid = 1'b1;
        sync     = (n == 0);
        iin      = dv;
        qin      = ~dv;
        advance  = (n == v.adv_n) || (n == v.both_n);
        retard   = (n == v.ret_n) || (n == v.both_n);
      end else begin
        in_valid = 1'b0; sync = 1'b1; advance = 1'b1; retard = 1'b0;
        iin = 4'sd7; qin = 4'sd7;
      end
      step();
      if (vld) n++;
      if (sym_valid) begin
        if (k < 3) begin
          check($sformatf("vec%0d_strobe%0d_time", idx, k), c, pick(k, v.c0, v.c1, v.c2));
          check($sformatf("vec%0d_strobe%0d_isym", idx, k), int'(isym), pick(k, v.i0, v.i1, v.i2));
          check($sformatf("vec%0d_strobe%0d_qsym", idx, k), int'(qsym), -pick(k, v.i0, v.i1, v.i2) - 1);
        end
        k++;
      end
    end
    check($sformatf("vec%0d_strobe_count", idx), k, 3);
    idle_inputs();
  endtask

  initial begin
    int s;
    //        ps gap adv ret both  c0  c1  c2   i0  i1  i2
    tbl[0] = '{5, 1'b0, -1, -1, -1,  5, 21, 37, -3, -3, -3};
    tbl[1] = '{0, 1'b0, 15, -1, -1,  0, 31, 47, -8,  7,  7};
    tbl[2] = '{0, 1'b0, -1,  3, -1,  0, 17, 33, -8, -7, -7};
    tbl[3] = '{5, 1'b1, -1, -1, -1, 10, 42, 74, -3, -3, -3};
    tbl[4] = '{0, 1'b0, -1, -1, 15,  0, 16, 32, -8, -8, -8};
    tbl[5] = '{15, 1'b0, 14, -1, -1, 30, 46, 62,  6,  6,  6};

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_isym", int'(isym), 0);
    check("rst_qsym", int'(qsym), 0);
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_locked", int'(locked), 0);
    rst_n = 1'b1;

    // Samples before any sync are discarded
    en = 1'b1;
    phase_sel = 4'd0;
    run_plain(5, 4'sd5, s);
    check("presync_strobes", s, 0);
    check("presync_locked", int'(locked), 0);

    // Sync sample carries I=+3/Q=-5
    in_valid = 1'b1; sync = 1'b1; iin = 4'sd3; qin = -4'sd5;
    step();
    check("sync_sym_valid", int'(sym_valid), 1);
    check("sync_isym", int'(isym), 3);
    check("sync_qsym", int'(qsym), -5);
    check("sync_locked", int'(locked), 1);
    run_plain(15, 4'sd0, s);
    check("sync_gap_strobes", s, 0);
    in_valid = 1'b1; sync = 1'b0; iin = 4'sd0; qin = 4'sd0;
    step();
    check("sync_repeat_valid", int'(sym_valid), 1);
    check("sync_repeat_isym", int'(isym), 0);

    // Async reset mid-symbol at cnt=7
    in_valid = 1'b1; sync = 1'b1; iin = 4'sd3; qin = -4'sd5;
    step();
    run_plain(6, 4'sd0, s);
    check("pre_async_isym", int'(isym), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_isym", int'(isym), 0);
    check("async_qsym", int'(qsym), 0);
    check("async_locked", int'(locked), 0);
    check("async_sym_valid", int'(sym_valid), 0);
    step();
    step();
    rst_n = 1'b1;
    run_plain(20, 4'sd5, s);
    check("post_reset_strobes", s, 0);
    check("post_reset_locked", int'(locked), 0);

    // Enable drop forces idle
    in_valid = 1'b1; sync = 1'b1; iin = 4'sd2; qin = 4'sd2;
    step();
    check("en_locked_before", int'(locked), 1);
    en = 1'b0; sync = 1'b0;
    step();
    check("en_off_locked", int'(locked), 0);
    check("en_off_sym_valid", int'(sym_valid), 0);
    en = 1'b1;
    run_plain(20, 4'sd5, s);
    check("en_off_strobes", s, 0);

    // Table-driven phase select, slips and gaps
    for (int t = 0; t < 6; t++) begin
      run_vec(t, tbl[t]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_downsampler.md
Name: qam_downsampler

Overview:
- Receive-side symbol decimator for the QAM16 chain; the counterpart of the transmit zero-stuffing upsampler.
- Accepts 4-bit signed I/Q at the oversampled rate, with OSR samples per symbol.
- Aligns an internal phase counter to a frame sync marker and emits one I/Q symbol per OSR valid input samples, at a programmable sample phase.
- Accepts one-sample advance/retard slips from the downstream timing-recovery loop.

Parameters:
- OSR, 16, samples per symbol; power of two, range 2..16.
- PW, 4, phase counter width; equals log2(OSR).
- DW, 4, I/Q sample width (signed two's complement).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- en  in  1  block enable; low forces S_IDLE on the next edge.
- in_valid  in  1  iin/qin carry a valid sample this cycle.
- sync  in  1  frame marker; qualified by in_valid; marks symbol phase 0.
- iin  in  DW  signed in-phase sample.
- qin  in  DW  signed quadrature sample.
- phase_sel  in  PW  sample phase captured within the symbol (0..OSR-1).
- advance  in  1  timing slip; drop one sample; qualified by in_valid.
- retard  in  1  timing slip; repeat one phase; qualified by in_valid.
- isym  out  DW  decimated in-phase symbol.
- qsym  out  DW  decimated quadrature symbol.
- sym_valid  out  1  one-cycle strobe; isym/qsym valid.
- locked  out  1  high while in S_TRACK.

Behaviour:
- Reset (reset=0, async): state=S_IDLE, cnt=0, isym=0, qsym=0, sym_valid=0, locked=0.
- States: S_IDLE, S_TRACK.
- S_IDLE:
  - Samples without sync are discarded.
  - On in_valid & sync & en: the sample takes effective phase p=0, cnt<=1 (mod OSR), go to S_TRACK.
- S_TRACK, on in_valid, effective phase p is:
  - 0 if sync=1;
  - otherwise cnt.
- S_TRACK, next cnt:
  - (p+1) mod OSR normally;
  - (p+2) mod OSR if advance & !retard;
  - p if retard & !advance;
  - advance & retard together: both ignored, (p+1) mod OSR.
- Capture: on in_valid with p==phase_sel (either state), isym<=iin, qsym<=qin, sym_valid<=1 on the next edge. Latency is 1 cycle.
- sym_valid is 0 on every other cycle. isym/qsym hold their last value between strobes.
- in_valid=0: cnt, state and outputs hold; sym_valid=0. advance, retard and sync are ignored.
- phase_sel is sampled live each cycle. A change mid-symbol may yield 0 or 2 captures in that symbol; this is legal.
- Wrap-around: advance at cnt=OSR-1 gives next cnt=1. The sample at phase 0 is skipped, so no capture that symbol if phase_sel=0.
- en=0: next state S_IDLE, cnt<=0, locked<=0, sym_valid<=0; isym/qsym hold.
- locked is registered: 1 on the cycle after entering S_TRACK, 0 on the cycle after leaving it.

Optional Feature:
- Macro QAM_DOWNSAMPLER_INTEGRATE_EN.
- Defined: integrate-and-dump replaces single-phase pick.
  - Signed accumulators of width DW+PW sum every valid sample in S_TRACK.
  - A sync sample restarts the accumulator with that sample.
  - At p==OSR-1: isym/qsym <= (acc+sample) >>> PW (arithmetic shift), sym_valid<=1 next edge, accumulator cleared.
  - phase_sel is ignored.
  - In S_IDLE only the sync sample is accumulated.
- Undefined: single-sample pick as above; no accumulator logic present.

Decomposition:
- Package qam_rx_pkg holds:
  - state enum localparams S_IDLE=1'b0, S_TRACK=1'b1;
  - QAM_DW=4;
  - default OSR=16.
- One natural sub-module: qam_phase_counter, holding cnt, sync realignment and advance/retard slip. It outputs p and a phase-match flag.
- Capture/output registers and the state machine stay in the top level.

Test Plan:
- Reset then sync: reset low, then high. Continuous in_valid, I=+3/Q=-5 at the sync sample, other samples 0. phase_sel=0 -> sym_valid one cycle after the sync sample with isym=3, qsym=-5; locked=1. Repeats every 16 samples.
- Phase select: phase_sel=5, sample k has iin=k[3:0]-8 -> every isym=-3, sym_valid period 16 valid cycles.
- Slips: phase_sel=0. advance pulse at cnt=15 -> no symbol that frame; next capture after 15 more samples. retard pulse at cnt=3 -> period 17 once.
- Gaps and simultaneous slips: in_valid toggled 1/0 -> period 32 clocks, values unchanged. advance&retard together -> period 16.
- Async reset mid-symbol: reset asserted at cnt=7 -> outputs 0 immediately without a clock. After release, no sym_valid until the next sync.
- Integrate build: QAM_DOWNSAMPLER_INTEGRATE_EN defined, all 16 samples I=+4 -> isym=4; samples alternating +7/-8 -> isym=-1.
